// File: rtl/seg_glyph_reader.sv
// rtl/seg_glyph_reader.sv - active-low seven-segment glyph stream to binary word decoder
// Collects one glyph per beat, LSB first, and flags non-binary or unknown glyphs per frame.
module seg_glyph_reader #(
  parameter int DIGITS = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seg_valid,
  input  logic              seg_first,
  input  logic [6:0]        seg,
  output logic [DIGITS-1:0] word_out,
  output logic              word_valid,
  output logic              glyph_err,
  output logic              range_err,
  output logic              frame_abort,
  output logic              busy
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [DIGITS-1:0] shift;
  logic              frame_glyph;
  logic              frame_range;

  logic              in_table;
  logic              beat_bit;
  logic              beat_glyph;
  logic              beat_range;
  logic [DIGITS-1:0] first_word;
  logic [DIGITS-1:0] coll_word;

  always_comb begin
    in_table = 1'b0;
    case (seg)
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E: in_table = 1'b1;
      default:                    in_table = 1'b0;
    endcase
    beat_bit   = (seg == 7'h79);
    beat_glyph = !in_table;
    // Any legal hex glyph that is not 0 or 1 decodes as 0 but marks the frame out of range.
    beat_range = in_table && (seg != 7'h40) && (seg != 7'h79);
    first_word = DIGITS'(beat_bit);
    coll_word  = shift;
    coll_word[idx] = beat_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      shift       <= '0;
      frame_glyph <= 1'b0;
      frame_range <= 1'b0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      glyph_err   <= 1'b0;
      range_err   <= 1'b0;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
    end else begin
      word_valid  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (seg_valid && seg_first) begin
            shift       <= first_word;
            idx         <= IW'(1);
            frame_glyph <= beat_glyph;
            frame_range <= beat_range;
            if (DIGITS == 1) begin
              word_out   <= first_word;
              glyph_err  <= beat_glyph;
              range_err  <= beat_range;
              word_valid <= 1'b1;
              idx        <= '0;
            end else begin
              state <= COLLECT;
              busy  <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (seg_valid) begin
            if (seg_first) begin
              // Resync: the partial frame is dropped and this beat becomes digit 0.
              frame_abort <= 1'b1;
              shift       <= first_word;
              idx         <= IW'(1);
              frame_glyph <= beat_glyph;
              frame_range <= beat_range;
            end else if (idx == LAST_IDX) begin
              word_out    <= coll_word;
              glyph_err   <= frame_glyph | beat_glyph;
              range_err   <= frame_range | beat_range;
              word_valid  <= 1'b1;
              shift       <= '0;
              idx         <= '0;
              frame_glyph <= 1'b0;
              frame_range <= 1'b0;
              state       <= IDLE;
              busy        <= 1'b0;
            end else begin
              shift       <= coll_word;
              idx         <= idx + IW'(1);
              frame_glyph <= frame_glyph | beat_glyph;
              frame_range <= frame_range | beat_range;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_glyph_reader.sv
// tb/tb_seg_glyph_reader.sv - table-driven and randomized checks for seg_glyph_reader
module tb_seg_glyph_reader;

  localparam int DIGITS = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              seg_valid = 1'b0;
  logic              seg_first = 1'b0;
  logic [6:0]        seg = 7'h7F;
  logic [DIGITS-1:0] word_out;
  logic              word_valid;
  logic              glyph_err;
  logic              range_err;
  logic              frame_abort;
  logic              busy;

  always #5 clk = ~clk;

  seg_glyph_reader #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .seg_valid(seg_valid), .seg_first(seg_first), .seg(seg),
    .word_out(word_out), .word_valid(word_valid), .glyph_err(glyph_err),
    .range_err(range_err), .frame_abort(frame_abort), .busy(busy)
  );

  typedef struct packed {
    logic [DIGITS-1:0] w;
    logic              g;
    logic              r;
  } res_t;

  typedef struct {
    logic [DIGITS*7-1:0] glyphs;
    logic [DIGITS-1:0]   word;
    logic                g;
    logic                r;
  } vec_t;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int failures = 0;

  // Reference model: frame as a list of decoded beats.
  logic              m_active = 1'b0;
  int                m_cnt = 0;
  logic [DIGITS-1:0] m_word = '0;
  logic              m_g = 1'b0;
  logic              m_r = 1'b0;
  res_t              exp_q[$];
  int                exp_aborts = 0;
  int                seen_aborts = 0;
  int                seen_valids = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void classify(input logic [6:0] s, output logic b, output logic g, output logic r);
    int hit = -1;
    for (int i = 0; i < 16; i++) if (glyph_tab[i] == s) hit = i;
    b = (hit == 1);
    g = (hit < 0);
    r = (hit > 1);
  endfunction

  function automatic logic [DIGITS*7-1:0] from_bits(input logic [DIGITS-1:0] b);
    logic [DIGITS*7-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[i*7 +: 7] = b[i] ? 7'h79 : 7'h40;
    return r;
  endfunction

  function automatic logic [6:0] rand_glyph();
    int         c = $urandom % 10;
    logic [31:0] u = $urandom;
    if (c < 4) return 7'h40;
    if (c < 8) return 7'h79;
    if (c == 8) return glyph_tab[$urandom % 16];
    return u[6:0];
  endfunction

  task automatic beat(input logic [6:0] g, input logic first);
    logic b, ge, re;
    @(negedge clk);
    seg_valid = 1'b1;
    seg       = g;
    seg_first = first;
    if (first) begin
      if (m_active) exp_aborts++;
      m_active = 1'b1; m_cnt = 0; m_word = '0; m_g = 1'b0; m_r = 1'b0;
    end
    if (m_active) begin
      classify(g, b, ge, re);
      m_word[m_cnt] = b;
      m_g |= ge;
      m_r |= re;
      m_cnt++;
      if (m_cnt == DIGITS) begin
        exp_q.push_back({m_word, m_g, m_r});
        m_active = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit stray);
    logic [31:0] u;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      u = $urandom;
      seg_valid = 1'b0;
      seg_first = stray ? u[0] : 1'b0;
      seg       = u[7:1];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DIGITS*7-1:0] g);
    for (int i = 0; i < DIGITS; i++) beat(g[i*7 +: 7], i == 0);
  endtask

  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      if (word_valid) begin
        seen_valids++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word_valid actual=%h required=none", word_out);
        end else begin
          e = exp_q.pop_front();
          check("model_word", 32'(word_out), 32'(e.w));
          check("model_flags", {30'd0, glyph_err, range_err}, {30'd0, e.g, e.r});
        end
      end
      if (frame_abort) seen_aborts++;
    end
  end

  vec_t vecs[7];

  initial begin
    logic [DIGITS*7-1:0] g;
    int s, va;

    vecs[0] = '{from_bits(14'h156B), 14'h156B, 1'b0, 1'b0};
    vecs[1] = '{from_bits(14'h3FFF), 14'h3FFF, 1'b0, 1'b0};
    vecs[2] = '{from_bits(14'h0000), 14'h0000, 1'b0, 1'b0};
    g = from_bits(14'h3FFF); g[5*7 +: 7] = 7'h24;
    vecs[3] = '{g, 14'h3FDF, 1'b0, 1'b1};
    vecs[4] = '{from_bits(14'h2A94), 14'h2A94, 1'b0, 1'b0};
    g = from_bits(14'h3FFF); g[13*7 +: 7] = 7'h7F;
    vecs[5] = '{g, 14'h1FFF, 1'b1, 1'b0};
    vecs[6] = '{from_bits(14'h0001), 14'h0001, 1'b0, 1'b0};

    #12;
    check("reset_outputs", {word_out, word_valid, glyph_err, range_err, frame_abort, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-frame: partial frame discarded silently.
    g = from_bits(14'h3FFF);
    for (int i = 0; i < 5; i++) beat(g[i*7 +: 7], i == 0);
    check("busy_mid_frame", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    m_active = 1'b0;
    #1;
    check("async_reset_outputs", {word_out, word_valid, glyph_err, range_err, frame_abort, busy}, 32'd0);
    idle(1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    va = seen_valids;
    for (int i = 5; i < DIGITS; i++) beat(g[i*7 +: 7], 1'b0);
    idle(2, 1'b0);
    check("no_valid_after_reset", 32'(seen_valids - va), 32'd0);
    check("idle_after_reset", 32'(busy), 32'd0);

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].glyphs);
      check($sformatf("vec%0d_valid", v), 32'(word_valid), 32'd1);
      check($sformatf("vec%0d_word", v), 32'(word_out), 32'(vecs[v].word));
      check($sformatf("vec%0d_flags", v), {30'd0, glyph_err, range_err}, {30'd0, vecs[v].g, vecs[v].r});
      idle(1, 1'b0);
      check($sformatf("vec%0d_valid_drop", v), 32'(word_valid), 32'd0);
      check($sformatf("vec%0d_word_hold", v), 32'(word_out), 32'(vecs[v].word));
    end

    // Abort and resync.
    s = seen_aborts;
    g = from_bits(14'h3FFF);
    for (int i = 0; i < 7; i++) beat(g[i*7 +: 7], i == 0);
    g = from_bits(14'h0000);
    beat(g[6:0], 1'b1);
    check("abort_pulse", 32'(frame_abort), 32'd1);
    for (int i = 1; i < DIGITS; i++) beat(g[i*7 +: 7], 1'b0);
    check("abort_no_stray_pulse", 32'(frame_abort), 32'd0);
    check("resync_valid", 32'(word_valid), 32'd1);
    check("resync_word", 32'(word_out), 32'd0);
    idle(2, 1'b0);
    check("abort_once", 32'(seen_aborts - s), 32'd1);

    // Back-to-back frames, then a gapped frame with stray seg_first.
    s = seen_aborts;
    va = seen_valids;
    send_frame(from_bits(14'h1234));
    check("b2b_first_valid", {30'd0, word_valid, busy}, 32'd2);
    g = from_bits(14'h2ABC);
    beat(g[6:0], 1'b1);
    check("b2b_second_busy", {30'd0, word_valid, busy}, 32'd1);
    for (int i = 1; i < DIGITS; i++) beat(g[i*7 +: 7], 1'b0);
    check("b2b_second_word", 32'(word_out), 32'h2ABC);
    g = from_bits(14'h0F0F);
    for (int i = 0; i < DIGITS; i++) begin
      if (i > 0 && ($urandom % 2) == 1) idle(1 + $urandom % 3, 1'b1);
      beat(g[i*7 +: 7], i == 0);
    end
    idle(2, 1'b0);
    check("gap_word", 32'(word_out), 32'h0F0F);
    check("three_valids", 32'(seen_valids - va), 32'd3);
    check("no_abort_b2b", 32'(seen_aborts - s), 32'd0);

    // Randomized frames with gaps, partial frames and stray beats.
    for (int f = 0; f < 40; f++) begin
      if ($urandom % 5 == 0) begin
        beat(rand_glyph(), 1'b1);
        for (int k = 0; k < int'($urandom % 8); k++) beat(rand_glyph(), 1'b0);
      end
      if ($urandom % 6 == 0) beat(rand_glyph(), 1'b0);
      for (int i = 0; i < DIGITS; i++) begin
        if ($urandom % 4 == 0) idle(1 + $urandom % 3, 1'b1);
        beat(rand_glyph(), i == 0);
      end
      if ($urandom % 2 == 0) idle(1, 1'b1);
    end
    idle(3, 1'b0);
    check("all_expected_seen", 32'(exp_q.size()), 32'd0);
    check("abort_count", 32'(seen_aborts), 32'(exp_aborts));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
